// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Instruction-decode stage of the 5-stage MIPS pipeline. It sits directly
//   downstream of fetch. The output register acts as the IF/ID/EX boundary,
//   so an instruction captured at edge N is visible on the outputs after N.
//   The stage reads the 32-entry register file. A write arriving from
//   writeback in the same cycle is bypassed into the captured operands.
//
// Ports
//   d_clk, d_rst          clock (rising edge), async active-high reset
//   d_i_ce/instr/pc       fetch output: valid, instruction word, its PC
//   d_i_stall             hold stage contents; rs/rt data keep refreshing
//   d_i_flush             squash: d_o_ce and all controls go to 0
//   d_i_wb_we/addr/data   writeback write port (writes to r0 are ignored)
//   d_o_ce, d_o_pc        decoded instruction valid and its PC
//   d_o_rs_*/d_o_rt_*     source register indices and operand data
//   d_o_rd_addr           resolved destination (0 when nothing is written)
//   d_o_imm               extended immediate
//   d_o_opcode/funct      raw opcode and funct fields
//   d_o_reg_write ...     control signals for the later stages
//
// Handshake: d_i_ce marks a valid instruction. It is consumed at the rising
// edge only when neither d_i_flush nor d_i_stall is asserted. There is no
// back-pressure toward fetch; the hazard unit owns that.
// -----------------------------------------------------------------------------
module decode_stage #(
   parameter int PC_WIDTH = 32,
   parameter int IWIDTH   = 32,
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 5
) (
   input  logic                d_clk,
   input  logic                d_rst,
   input  logic                d_i_ce,
   input  logic [IWIDTH-1:0]   d_i_instr,
   input  logic [PC_WIDTH-1:0] d_i_pc,
   input  logic                d_i_stall,
   input  logic                d_i_flush,
   input  logic                d_i_wb_we,
   input  logic [AWIDTH-1:0]   d_i_wb_addr,
   input  logic [DWIDTH-1:0]   d_i_wb_data,
   output logic                d_o_ce,
   output logic [PC_WIDTH-1:0] d_o_pc,
   output logic [AWIDTH-1:0]   d_o_rs_addr,
   output logic [AWIDTH-1:0]   d_o_rt_addr,
   output logic [DWIDTH-1:0]   d_o_rs_data,
   output logic [DWIDTH-1:0]   d_o_rt_data,
   output logic [AWIDTH-1:0]   d_o_rd_addr,
   output logic [DWIDTH-1:0]   d_o_imm,
   output logic [5:0]          d_o_opcode,
   output logic [5:0]          d_o_funct,
   output logic                d_o_reg_write,
   output logic                d_o_mem_read,
   output logic                d_o_mem_write,
   output logic                d_o_mem_to_reg,
   output logic                d_o_alu_src,
   output logic                d_o_branch,
   output logic                d_o_jump,
   output logic                d_o_illegal
);

   localparam int NREGS = 2 ** AWIDTH;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   // Control bundle bit positions.
   localparam int C_RW  = 0;
   localparam int C_MR  = 1;
   localparam int C_MW  = 2;
   localparam int C_M2R = 3;
   localparam int C_AS  = 4;
   localparam int C_BR  = 5;
   localparam int C_JP  = 6;
   localparam int C_IL  = 7;

   // ---------------------------------------------------------------------
   // Field extraction
   // ---------------------------------------------------------------------
   logic [5:0]        f_opcode;
   logic [5:0]        f_funct;
   logic [AWIDTH-1:0] f_rs;
   logic [AWIDTH-1:0] f_rt;
   logic [AWIDTH-1:0] f_rd;
   logic [15:0]       f_imm16;
   logic [25:0]       f_target;

   assign f_opcode = d_i_instr[31:26];
   assign f_funct  = d_i_instr[5:0];
   assign f_rs     = d_i_instr[25:21];
   assign f_rt     = d_i_instr[20:16];
   assign f_rd     = d_i_instr[15:11];
   assign f_imm16  = d_i_instr[15:0];
   assign f_target = d_i_instr[25:0];

   // ---------------------------------------------------------------------
   // Decode table
   // ---------------------------------------------------------------------
   logic [7:0]        dec_ctrl;
   logic [AWIDTH-1:0] dec_rd;
   logic [DWIDTH-1:0] dec_imm;
   logic [DWIDTH-1:0] imm_sext;
   logic [DWIDTH-1:0] imm_zext;

   assign imm_sext = {{(DWIDTH-16){f_imm16[15]}}, f_imm16};
   assign imm_zext = {{(DWIDTH-16){1'b0}}, f_imm16};

   always_comb begin
      dec_ctrl = '0;
      dec_rd   = '0;
      dec_imm  = imm_sext;
      case (f_opcode)
         OP_RTYPE: begin
            if (f_funct == FN_JR) begin
               dec_ctrl[C_JP] = 1'b1;
            end else begin
               dec_ctrl[C_RW] = 1'b1;
               dec_rd         = f_rd;
            end
         end
         OP_LW: begin
            dec_ctrl[C_RW]  = 1'b1;
            dec_ctrl[C_MR]  = 1'b1;
            dec_ctrl[C_M2R] = 1'b1;
            dec_ctrl[C_AS]  = 1'b1;
            dec_rd          = f_rt;
         end
         OP_SW: begin
            dec_ctrl[C_MW] = 1'b1;
            dec_ctrl[C_AS] = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            dec_ctrl[C_BR] = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI: begin
            dec_ctrl[C_RW] = 1'b1;
            dec_ctrl[C_AS] = 1'b1;
            dec_rd         = f_rt;
         end
         OP_ANDI, OP_ORI: begin
            dec_ctrl[C_RW] = 1'b1;
            dec_ctrl[C_AS] = 1'b1;
            dec_rd         = f_rt;
            dec_imm        = imm_zext;
         end
         OP_LUI: begin
            dec_ctrl[C_RW] = 1'b1;
            dec_ctrl[C_AS] = 1'b1;
            dec_rd         = f_rt;
            dec_imm        = imm_zext << 16;
         end
         OP_J: begin
            dec_ctrl[C_JP] = 1'b1;
            dec_imm        = {{(DWIDTH-26){1'b0}}, f_target};
         end
         OP_JAL: begin
            dec_ctrl[C_JP] = 1'b1;
            dec_ctrl[C_RW] = 1'b1;
            dec_rd         = AWIDTH'(31);
            dec_imm        = {{(DWIDTH-26){1'b0}}, f_target};
         end
         default: begin
            dec_ctrl[C_IL] = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Register file with write-port bypass
   // ---------------------------------------------------------------------
   logic [DWIDTH-1:0] regs [NREGS];
   logic              capture;
   logic [AWIDTH-1:0] rs_sel;
   logic [AWIDTH-1:0] rt_sel;
   logic [DWIDTH-1:0] rs_rd;
   logic [DWIDTH-1:0] rt_rd;

   // While stalled, the operands are re-read from the held indices. That way
   // a writeback landing during the stall reaches the waiting instruction.
   assign capture = !d_i_flush && !d_i_stall && d_i_ce;
   assign rs_sel  = d_i_stall ? d_o_rs_addr : f_rs;
   assign rt_sel  = d_i_stall ? d_o_rt_addr : f_rt;

   always_comb begin
      rs_rd = regs[rs_sel];
      if (rs_sel == '0) begin
         rs_rd = '0;
      end else if (d_i_wb_we && d_i_wb_addr == rs_sel) begin
         rs_rd = d_i_wb_data;
      end
   end

   always_comb begin
      rt_rd = regs[rt_sel];
      if (rt_sel == '0) begin
         rt_rd = '0;
      end else if (d_i_wb_we && d_i_wb_addr == rt_sel) begin
         rt_rd = d_i_wb_data;
      end
   end

   always_ff @(posedge d_clk or posedge d_rst) begin
      if (d_rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (d_i_wb_we && d_i_wb_addr != '0) begin
         regs[d_i_wb_addr] <= d_i_wb_data;
      end
   end

   // ---------------------------------------------------------------------
   // Output register: flush > stall > capture > bubble
   // ---------------------------------------------------------------------
   logic [7:0] ctrl_q;

   always_ff @(posedge d_clk or posedge d_rst) begin
      if (d_rst) begin
         d_o_ce      <= 1'b0;
         d_o_pc      <= '0;
         d_o_rs_addr <= '0;
         d_o_rt_addr <= '0;
         d_o_rs_data <= '0;
         d_o_rt_data <= '0;
         d_o_rd_addr <= '0;
         d_o_imm     <= '0;
         d_o_opcode  <= '0;
         d_o_funct   <= '0;
         ctrl_q      <= '0;
      end else if (d_i_flush) begin
         d_o_ce <= 1'b0;
         ctrl_q <= '0;
      end else if (d_i_stall) begin
         d_o_rs_data <= rs_rd;
         d_o_rt_data <= rt_rd;
      end else if (capture) begin
         d_o_ce      <= 1'b1;
         d_o_pc      <= d_i_pc;
         d_o_rs_addr <= f_rs;
         d_o_rt_addr <= f_rt;
         d_o_rs_data <= rs_rd;
         d_o_rt_data <= rt_rd;
         d_o_rd_addr <= dec_rd;
         d_o_imm     <= dec_imm;
         d_o_opcode  <= f_opcode;
         d_o_funct   <= f_funct;
         ctrl_q      <= dec_ctrl;
      end else begin
         d_o_ce <= 1'b0;
         ctrl_q <= '0;
      end
   end

   assign d_o_reg_write  = ctrl_q[C_RW];
   assign d_o_mem_read   = ctrl_q[C_MR];
   assign d_o_mem_write  = ctrl_q[C_MW];
   assign d_o_mem_to_reg = ctrl_q[C_M2R];
   assign d_o_alu_src    = ctrl_q[C_AS];
   assign d_o_branch     = ctrl_q[C_BR];
   assign d_o_jump       = ctrl_q[C_JP];
   assign d_o_illegal    = ctrl_q[C_IL];

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage.
- Consumes the fetch outputs (instruction, PC, clock-enable) through an internal IF/ID register.
- Reads the 32-entry register file, with write-port bypass from writeback.
- Produces registered operands, immediate, destination and control signals for execute, with stall and flush handling.

Parameters:
- PC_WIDTH, 32, PC width; matches `PC_WIDTH.
- IWIDTH, 32, instruction width; matches `IWIDTH.
- DWIDTH, 32, register data width.
- AWIDTH, 5, register address width.

Ports:
- d_clk  in  1  clock, rising edge.
- d_rst  in  1  reset, asynchronous, active-high.
- d_i_ce  in  1  fetch output valid (fetch o_ce).
- d_i_instr  in  IWIDTH  fetched instruction.
- d_i_pc  in  PC_WIDTH  PC of fetched instruction.
- d_i_stall  in  1  hold stage contents (hazard unit).
- d_i_flush  in  1  squash stage contents (branch/jump taken).
- d_i_wb_we  in  1  writeback write enable.
- d_i_wb_addr  in  AWIDTH  writeback register index.
- d_i_wb_data  in  DWIDTH  writeback data.
- d_o_ce  out  1  decoded instruction valid.
- d_o_pc  out  PC_WIDTH  PC of decoded instruction.
- d_o_rs_addr / d_o_rt_addr  out  AWIDTH each  source indices.
- d_o_rs_data / d_o_rt_data  out  DWIDTH each  source operands.
- d_o_rd_addr  out  AWIDTH  resolved destination index.
- d_o_imm  out  DWIDTH  extended immediate.
- d_o_opcode  out  6  opcode.
- d_o_funct  out  6  funct field.
- d_o_reg_write, d_o_mem_read, d_o_mem_write, d_o_mem_to_reg, d_o_alu_src, d_o_branch, d_o_jump, d_o_illegal  out  1 each  control signals.

Behaviour:
- Reset (d_rst=1, async): all outputs 0; all 32 registers cleared to 0. Release is on any edge; the first capture occurs at the next d_clk rise.
- Latency: an instruction presented with d_i_ce=1 at rising edge N appears decoded on the outputs after edge N (1 cycle).
- Priority per edge is flush > stall > normal.
  - Flush: d_o_ce=0 and all control outputs 0. Data and address outputs may hold.
  - Stall (no flush): all outputs hold, except d_o_rs_data/d_o_rt_data.
  - Operand refresh under stall: rs/rt data are re-read each cycle for the held rs/rt addresses, so writes landing during a stall are observed.
  - Normal with d_i_ce=0: bubble; d_o_ce=0, controls 0.
- Register file:
  - Write at rising edge when d_i_wb_we=1 and d_i_wb_addr!=0.
  - r0 always reads 0.
  - Same-cycle bypass: if a write targets a nonzero rs/rt being captured, the captured data is d_i_wb_data.
- Decode table (unlisted controls are 0):
  - R-type 0x00: dest rd, reg_write=1. funct 0x08 (jr) instead gives reg_write=0, jump=1.
  - lw 0x23: dest rt, sign-extend, alu_src, mem_read, mem_to_reg, reg_write.
  - sw 0x2B: sign-extend, alu_src, mem_write.
  - beq 0x04 / bne 0x05: sign-extend, branch.
  - addi 0x08 / addiu 0x09 / slti 0x0A: dest rt, sign-extend, alu_src, reg_write.
  - andi 0x0C / ori 0x0D: dest rt, zero-extend, alu_src, reg_write.
  - lui 0x0F: dest rt, imm = {imm16,16'h0}, alu_src, reg_write.
  - j 0x02: jump. jal 0x03: jump, reg_write, dest 31.
  - Other opcodes: illegal=1, all other controls 0, d_o_ce=1.
- Fields are always extracted: rs=instr[25:21], rt=[20:16], rd=[15:11]. d_o_imm for j/jal is the zero-extended instr[25:0].
- Reset asserted mid-stall or mid-flush: outputs 0 immediately; no pending state survives.

Test Plan:
- Reset: assert d_rst for 2 cycles mid-operation -> all outputs 0 immediately; r5 previously written reads 0 afterwards.
- Operand read and bypass:
  - Write r8=0x0000_1234 via wb, then feed addi r9,r8,-1 (0x2109FFFF) with d_i_ce=1, pc=0x40 -> next cycle: d_o_ce=1, pc=0x40, rs_data=0x1234, rd_addr=9, imm=0xFFFFFFFF, reg_write=1, alu_src=1.
  - Same-cycle bypass: wb writes r8=0xAA while addi above is captured -> rs_data=0xAA.
  - wb to r0 with 0xFFFF -> later rs=r0 reads 0.
- Stall: present lw then assert d_i_stall 3 cycles with new instrs -> lw outputs hold. A wb write to its rs during the stall updates d_o_rs_data. Deassert -> next instr appears 1 cycle later.
- Flush over stall: d_i_stall=1 and d_i_flush=1 together -> d_o_ce=0, reg_write=mem_read=branch=jump=0 next cycle.
- Decode coverage: 0x3C01ABCD (lui) -> imm=0xABCD0000; 0x3421F000 (ori) -> imm=0x0000F000; 0x0C000010 (jal) -> jump=1, reg_write=1, rd_addr=31; 0x03E00008 (jr) -> jump=1, reg_write=0; 0xFC000000 -> illegal=1, d_o_ce=1.
